// File: rtl/io_port_if.sv
// io_port_if: CPU strobe, sink stream, source stream and status signals of
// the io_port_responder. The master modport is the CPU/environment side,
// the slave modport is the responder side.
interface io_port_if #(
    parameter int DATA_W = 16
);
    logic              Wr;
    logic              Rd;
    logic [DATA_W-1:0] Wr_Data;
    logic [DATA_W-1:0] Rd_Data;
    logic [DATA_W-1:0] Out_Data;
    logic              Out_Valid;
    logic              Out_Ready;
    logic [DATA_W-1:0] In_Data;
    logic              In_Valid;
    logic              In_Ready;
    logic              Out_Full;
    logic              In_Avail;
    logic              Ovf_Err;
    logic              Udf_Err;

    modport master (
        output Wr, Rd, Wr_Data, Out_Ready, In_Data, In_Valid,
        input  Rd_Data, Out_Data, Out_Valid, In_Ready, Out_Full, In_Avail,
               Ovf_Err, Udf_Err
    );

    modport slave (
        input  Wr, Rd, Wr_Data, Out_Ready, In_Data, In_Valid,
        output Rd_Data, Out_Data, Out_Valid, In_Ready, Out_Full, In_Avail,
               Ovf_Err, Udf_Err
    );
endinterface

// File: rtl/io_port_responder.sv
// io_port_responder: device-side responder for the CPU Wr/Rd strobes.
// Wr pushes into an output FIFO drained over valid/ready; Rd consumes a
// one-entry holding register filled over valid/ready. Rd_Data is
// combinational so the CPU can capture it in the same cycle as Rd.
// Optional build macro IO_LOOPBACK_EN adds Loop_Mode, which routes the
// FIFO head into the holding register instead of the external streams.
module io_port_responder #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic      Clock_Puls,
    input  logic      Reset,
`ifdef IO_LOOPBACK_EN
    input  logic      Loop_Mode,
`endif
    io_port_if.slave  bus
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [DATA_W-1:0] hold;
    logic              hold_valid;
    logic              ovf_err;
    logic              udf_err;

    logic              loop_mode;
    logic              out_valid_int;
    logic              out_full;
    logic              in_ready_int;
    logic              pop;
    logic              push;
    logic              cap_valid;
    logic [DATA_W-1:0] cap_data;
    logic              cap;
    logic [DATA_W-1:0] head;

`ifdef IO_LOOPBACK_EN
    assign loop_mode = Loop_Mode;
`else
    assign loop_mode = 1'b0;
`endif

    assign head          = mem[rd_ptr];
    assign out_valid_int = (count != '0);
    assign out_full      = (count == DEPTH_C);
    // A Rd frees the holding register in the same cycle, so a new word may
    // land while the old one is being returned.
    assign in_ready_int  = ~hold_valid | bus.Rd;

    // In loopback the holding register is the FIFO's consumer.
    assign pop       = out_valid_int & (loop_mode ? in_ready_int : bus.Out_Ready);
    assign push      = bus.Wr & (~out_full | pop);
    assign cap_valid = loop_mode ? out_valid_int : bus.In_Valid;
    assign cap_data  = loop_mode ? head : bus.In_Data;
    assign cap       = cap_valid & in_ready_int;

    assign bus.Out_Data  = head;
    assign bus.Out_Valid = out_valid_int & ~loop_mode;
    assign bus.Out_Full  = out_full;
    assign bus.In_Ready  = in_ready_int & ~loop_mode;
    assign bus.In_Avail  = hold_valid;
    assign bus.Rd_Data   = hold_valid ? hold : '0;
    assign bus.Ovf_Err   = ovf_err;
    assign bus.Udf_Err   = udf_err;

    // FIFO storage; contents are left untouched by reset.
    always_ff @(posedge Clock_Puls) begin
        if (push) begin
            mem[wr_ptr] <= bus.Wr_Data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge Clock_Puls) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Input holding register: capture wins over consumption when both occur.
    always_ff @(posedge Clock_Puls) begin
        if (Reset) begin
            hold       <= '0;
            hold_valid <= 1'b0;
        end else if (cap) begin
            hold       <= cap_data;
            hold_valid <= 1'b1;
        end else if (bus.Rd && hold_valid) begin
            hold_valid <= 1'b0;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge Clock_Puls) begin
        if (Reset) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (bus.Wr && out_full && !pop) begin
                ovf_err <= 1'b1;
            end
            if (bus.Rd && !hold_valid) begin
                udf_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_port_responder.sv
// tb_io_port_responder: scoreboard bench for io_port_responder. Expected
// sink words and Rd_Data values are queued as stimulus is driven and are
// compared when the DUT transfers a word or sees a Rd strobe.
module tb_io_port_responder;

    localparam int DATA_W = 16;

    logic Clock_Puls = 1'b0;
    logic Reset      = 1'b1;
`ifdef IO_LOOPBACK_EN
    logic Loop_Mode  = 1'b0;
`endif

    io_port_if #(.DATA_W(DATA_W)) bus ();

    io_port_responder #(.DATA_W(DATA_W), .FIFO_DEPTH(4), .PTR_W(2)) dut (
        .Clock_Puls (Clock_Puls),
        .Reset      (Reset),
`ifdef IO_LOOPBACK_EN
        .Loop_Mode  (Loop_Mode),
`endif
        .bus        (bus)
    );

    always #5 Clock_Puls = ~Clock_Puls;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] out_q [$];
    logic [DATA_W-1:0] rd_q  [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Sink and CPU-read scoreboard; inputs are stable from negedge to posedge.
    always @(negedge Clock_Puls) begin
        logic [DATA_W-1:0] e;
        #2;
        if (bus.Out_Valid === 1'b1 && bus.Out_Ready === 1'b1) begin
            if (out_q.size() == 0) begin
                check_eq("out_extra", 32'(bus.Out_Data), 32'hFFFF_FFFF);
            end else begin
                e = out_q.pop_front();
                check_eq("out_data", 32'(bus.Out_Data), 32'(e));
            end
        end
        if (bus.Rd === 1'b1) begin
            if (rd_q.size() == 0) begin
                check_eq("rd_extra", 32'(bus.Rd_Data), 32'hFFFF_FFFF);
            end else begin
                e = rd_q.pop_front();
                check_eq("rd_data", 32'(bus.Rd_Data), 32'(e));
            end
        end
    end

    task automatic do_reset();
        @(negedge Clock_Puls);
        Reset = 1'b1;
        bus.Wr = 1'b0;
        bus.Rd = 1'b0;
        bus.Out_Ready = 1'b0;
        bus.In_Valid = 1'b0;
        @(negedge Clock_Puls);
        Reset = 1'b0;
        #1;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock_Puls);
            #3;
            if (out_q.size() == 0) break;
        end
        check_eq("drain_left", 32'(out_q.size()), 32'h0);
        @(negedge Clock_Puls);
        bus.Out_Ready = 1'b0;
        #1;
        check_eq("drain_out_valid", 32'(bus.Out_Valid), 32'h0);
    endtask

    initial begin
        bus.Wr = 1'b0;
        bus.Rd = 1'b0;
        bus.Wr_Data = '0;
        bus.Out_Ready = 1'b0;
        bus.In_Data = '0;
        bus.In_Valid = 1'b0;

        // Reset state
        do_reset();
        check_eq("rst_out_valid", 32'(bus.Out_Valid), 32'h0);
        check_eq("rst_out_full",  32'(bus.Out_Full),  32'h0);
        check_eq("rst_in_avail",  32'(bus.In_Avail),  32'h0);
        check_eq("rst_in_ready",  32'(bus.In_Ready),  32'h1);
        check_eq("rst_rd_data",   32'(bus.Rd_Data),   32'h0);
        check_eq("rst_errs",      32'({bus.Ovf_Err, bus.Udf_Err}), 32'h0);

        // Two writes, sink stalled, then drain
        @(negedge Clock_Puls);
        bus.Wr = 1'b1; bus.Wr_Data = 16'h1234; out_q.push_back(16'h1234);
        #1;
        check_eq("t1_valid_pre", 32'(bus.Out_Valid), 32'h0);
        @(negedge Clock_Puls);
        bus.Wr_Data = 16'h5678; out_q.push_back(16'h5678);
        #1;
        check_eq("t1_valid_post", 32'(bus.Out_Valid), 32'h1);
        check_eq("t1_head",       32'(bus.Out_Data),  32'h1234);
        @(negedge Clock_Puls);
        bus.Wr = 1'b0;
        bus.Out_Ready = 1'b1;
        wait_drain(20);

        // Overflow: five writes into a four-entry FIFO
        for (int i = 1; i <= 5; i++) begin
            @(negedge Clock_Puls);
            bus.Wr = 1'b1;
            bus.Wr_Data = 16'(i);
            if (i <= 4) out_q.push_back(16'(i));
            #1;
            if (i == 5) check_eq("t2_full_at5", 32'(bus.Out_Full), 32'h1);
        end
        @(negedge Clock_Puls);
        bus.Wr = 1'b0;
        #1;
        check_eq("t2_ovf",       32'(bus.Ovf_Err),  32'h1);
        check_eq("t2_full_post", 32'(bus.Out_Full), 32'h1);
        bus.Out_Ready = 1'b1;
        wait_drain(20);

        // Reset discards buffered data and clears the sticky error
        @(negedge Clock_Puls);
        bus.Wr = 1'b1; bus.Wr_Data = 16'h0F0F;
        @(negedge Clock_Puls);
        bus.Wr = 1'b0;
        #1;
        check_eq("mid_valid_pre", 32'(bus.Out_Valid), 32'h1);
        do_reset();
        check_eq("mid_valid_post", 32'(bus.Out_Valid), 32'h0);
        check_eq("mid_ovf_clear",  32'(bus.Ovf_Err),   32'h0);

        // Push while full with a simultaneous pop
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock_Puls);
            bus.Wr = 1'b1;
            bus.Wr_Data = 16'h0010 + 16'(i);
            out_q.push_back(16'h0010 + 16'(i));
        end
        @(negedge Clock_Puls);
        bus.Wr = 1'b0;
        #1;
        check_eq("t3_full", 32'(bus.Out_Full), 32'h1);
        @(negedge Clock_Puls);
        bus.Wr = 1'b1; bus.Wr_Data = 16'h00AA; bus.Out_Ready = 1'b1;
        out_q.push_back(16'h00AA);
        @(negedge Clock_Puls);
        bus.Wr = 1'b0; bus.Out_Ready = 1'b0;
        #1;
        check_eq("t3_full_kept", 32'(bus.Out_Full), 32'h1);
        check_eq("t3_no_ovf",    32'(bus.Ovf_Err),  32'h0);
        bus.Out_Ready = 1'b1;
        wait_drain(20);

        // Holding register fill, read, then read while empty
        @(negedge Clock_Puls);
        bus.In_Valid = 1'b1; bus.In_Data = 16'hBEEF;
        #1;
        check_eq("t4_ready_empty", 32'(bus.In_Ready), 32'h1);
        @(negedge Clock_Puls);
        bus.In_Valid = 1'b0;
        #1;
        check_eq("t4_avail",       32'(bus.In_Avail), 32'h1);
        check_eq("t4_ready_full",  32'(bus.In_Ready), 32'h0);
        @(negedge Clock_Puls);
        bus.Rd = 1'b1; rd_q.push_back(16'hBEEF);
        #1;
        check_eq("t4_ready_on_rd", 32'(bus.In_Ready), 32'h1);
        @(negedge Clock_Puls);
        bus.Rd = 1'b0;
        #1;
        check_eq("t4_avail_after", 32'(bus.In_Avail), 32'h0);
        check_eq("t4_udf_pre",     32'(bus.Udf_Err),  32'h0);
        @(negedge Clock_Puls);
        bus.Rd = 1'b1; rd_q.push_back(16'h0000);
        @(negedge Clock_Puls);
        bus.Rd = 1'b0;
        #1;
        check_eq("t4_udf", 32'(bus.Udf_Err), 32'h1);

        // Read and capture in the same cycle
        @(negedge Clock_Puls);
        bus.In_Valid = 1'b1; bus.In_Data = 16'h1111;
        @(negedge Clock_Puls);
        bus.In_Data = 16'h2222;
        @(negedge Clock_Puls);
        bus.Rd = 1'b1; rd_q.push_back(16'h1111);
        @(negedge Clock_Puls);
        bus.Rd = 1'b0; bus.In_Valid = 1'b0;
        #1;
        check_eq("t5_avail_kept", 32'(bus.In_Avail), 32'h1);
        @(negedge Clock_Puls);
        bus.Rd = 1'b1; rd_q.push_back(16'h2222);
        @(negedge Clock_Puls);
        bus.Rd = 1'b0;
        #1;
        check_eq("t5_avail_end", 32'(bus.In_Avail), 32'h0);

`ifdef IO_LOOPBACK_EN
        // Loopback: FIFO head drains into the holding register
        do_reset();
        Loop_Mode = 1'b1;
        @(negedge Clock_Puls);
        bus.Wr = 1'b1; bus.Wr_Data = 16'h0C0C;
        @(negedge Clock_Puls);
        bus.Wr = 1'b0;
        #1;
        check_eq("lp_out_valid1", 32'(bus.Out_Valid), 32'h0);
        check_eq("lp_in_ready",   32'(bus.In_Ready),  32'h0);
        @(negedge Clock_Puls);
        #1;
        check_eq("lp_out_valid2", 32'(bus.Out_Valid), 32'h0);
        check_eq("lp_in_avail",   32'(bus.In_Avail),  32'h1);
        @(negedge Clock_Puls);
        bus.Rd = 1'b1; rd_q.push_back(16'h0C0C);
        @(negedge Clock_Puls);
        bus.Rd = 1'b0;
        Loop_Mode = 1'b0;
`endif

        @(negedge Clock_Puls);
        #3;
        check_eq("out_q_empty", 32'(out_q.size()), 32'h0);
        check_eq("rd_q_empty",  32'(rd_q.size()),  32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
